// File: rtl/rv32_muldiv_pkg.sv
// Shared constants, state encoding and operand-signedness helpers for the
// RV32M iterative multiply/divide unit.
package rv32_muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q  = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic a_is_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/rv32_muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// Handshake: start is taken on a clock edge only while the unit is idle or
// done; busy is high while computing; done pulses for one cycle with result
// valid, and result holds until the next operation completes.
interface rv32_muldiv_if
  import rv32_muldiv_pkg::*;
;
  logic                    start;
  logic [2:0]              funct3;
  logic [XLEN_DEFAULT-1:0] a;
  logic [XLEN_DEFAULT-1:0] b;
  logic                    flush;
  logic                    busy;
  logic                    done;
  logic [XLEN_DEFAULT-1:0] result;

  modport master (
    output start, funct3, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/rv32_muldiv_sign.sv
// Sign handling shared by the multiply and divide paths: operand magnitudes
// on the way in, conditional two's-complement negation on the way out.
module rv32_muldiv_sign
  import rv32_muldiv_pkg::*;
#(
  parameter int W = XLEN_DEFAULT
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           a_signed_i,
  input  logic           b_signed_i,
  output logic [W-1:0]   abs_a_o,
  output logic [W-1:0]   abs_b_o,
  output logic           sign_a_o,
  output logic           sign_b_o,
  input  logic [2*W-1:0] val_i,
  input  logic           neg_i,
  output logic [2*W-1:0] val_o
);
  assign sign_a_o = a_signed_i & a_i[W-1];
  assign sign_b_o = b_signed_i & b_i[W-1];
  // Magnitude of the most negative value wraps to itself, which is its
  // correct unsigned magnitude.
  assign abs_a_o  = sign_a_o ? -a_i : a_i;
  assign abs_b_o  = sign_b_o ? -b_i : b_i;
  assign val_o    = neg_i ? -val_i : val_i;
endmodule

// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FASTMUL_EN to replace the iterative multiply with a one-cycle
// 33x33 signed multiplier; divide timing is unaffected.
module rv32_muldiv_unit
  import rv32_muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  rv32_muldiv_if.slave bus,
  output state_t       dbg_state_o
);
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [2:0]          f3_q, f3_d;
  logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic [XLEN-1:0]     abs_a, abs_b;
  logic                sign_a, sign_b;
  logic [2*XLEN-1:0]   fix_in, fix_out;
  logic                fix_neg;
  logic [XLEN-1:0]     fix_word;
  logic                is_ovf;

  rv32_muldiv_sign #(.W(XLEN)) u_sign (
    .a_i        (bus.a),
    .b_i        (bus.b),
    .a_signed_i (a_is_signed(bus.funct3)),
    .b_signed_i (b_is_signed(bus.funct3)),
    .abs_a_o    (abs_a),
    .abs_b_o    (abs_b),
    .sign_a_o   (sign_a),
    .sign_b_o   (sign_b),
    .val_i      (fix_in),
    .neg_i      (fix_neg),
    .val_o      (fix_out)
  );

  // acc_q holds {hi, lo}: product for multiply, {remainder, dividend/quotient}
  // for divide; mcand_q holds |a| (multiply) or |b| (divide).
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_sh, div_diff;
  logic                q_bit;
  logic [2*XLEN-1:0]   div_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = rem_sh - {1'b0, mcand_q};
  assign q_bit    = ~div_diff[XLEN];
  assign div_next = {(q_bit ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};

`ifdef MULDIV_FASTMUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  assign fast_prod = $signed({sign_a, bus.a}) * $signed({sign_b, bus.b});
`endif

  assign is_ovf = !bus.funct3[0] && (bus.a == OVF_Q) && (bus.b == DIV0_Q);

  always_comb begin
    fix_in  = acc_q;
    fix_neg = sign_a_q ^ sign_b_q;
    if (f3_q[2]) begin
      fix_in = f3_q[1] ? {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                       : {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
      // Remainder follows the dividend; quotient follows the sign product.
      if (f3_q[1]) fix_neg = sign_a_q;
    end
`ifdef MULDIV_FASTMUL_EN
    else begin
      fix_neg = 1'b0;
    end
`endif
  end

  assign fix_word = (!f3_q[2] && (f3_q[1:0] != 2'b00)) ? fix_out[2*XLEN-1:XLEN]
                                                       : fix_out[XLEN-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    f3_d     = f3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start && !bus.flush) begin
          f3_d     = bus.funct3;
          sign_a_d = sign_a;
          sign_b_d = sign_b;
          cnt_d    = '0;
          if (!bus.funct3[2]) begin
            mcand_d = abs_a;
`ifdef MULDIV_FASTMUL_EN
            acc_d   = fast_prod[2*XLEN-1:0];
            state_d = ST_FIX;
`else
            acc_d   = {{XLEN{1'b0}}, abs_b};
            state_d = ST_MUL;
`endif
          end else if (bus.b == '0) begin
            result_d = bus.funct3[1] ? bus.a : DIV0_Q;
            state_d  = ST_DONE;
          end else if (is_ovf) begin
            result_d = bus.funct3[1] ? '0 : OVF_Q;
            state_d  = ST_DONE;
          end else begin
            mcand_d = abs_b;
            acc_d   = {{XLEN{1'b0}}, abs_a};
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = (state_q == ST_MUL) ? mul_next : div_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          result_d = fix_word;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      f3_q     <= f3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
    end
  end

  assign bus.busy    = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.result  = result_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Directed bench for rv32_muldiv_unit: arithmetic/latency reference model
// checked every cycle, plus hand-computed literals for each vector.
module tb_rv32_muldiv_unit;
  import rv32_muldiv_pkg::*;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  rv32_muldiv_if bus ();

  rv32_muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FASTMUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  int          m_left   = 0;
  logic [31:0] m_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint unsigned  ua, ub;
    longint           sa, sb;
    logic [63:0]      p;
    logic signed [31:0] qa, qb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qa = a;
    qb = b;
    p  = '0;
    ref_result = '0;
    case (f3)
      F3_MUL:    begin p = ua * ub; ref_result = p[31:0]; end
      F3_MULH:   begin p = sa * sb; ref_result = p[63:32]; end
      F3_MULHSU: begin p = sa * longint'(ub); ref_result = p[63:32]; end
      F3_MULHU:  begin p = ua * ub; ref_result = p[63:32]; end
      F3_DIV: begin
        if (b == 0) ref_result = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h8000_0000;
        else ref_result = qa / qb;
      end
      F3_DIVU: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) ref_result = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h0;
        else ref_result = qa % qb;
      end
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from accepting edge until the done cycle.
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3 < 3'd4) return MUL_LAT;
    if (b == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Model: m_left = cycles remaining (1 means the done cycle, >1 busy).
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left   = 0;
        m_result = '0;
        exp_q.delete();
      end else if (m_left > 1 && bus.flush) begin
        m_left = 0;
        exp_q.delete();
      end else if (m_left <= 1 && bus.start && !bus.flush) begin
        exp_q.push_back(ref_result(bus.funct3, bus.a, bus.b));
        m_left = ref_latency(bus.funct3, bus.a, bus.b);
        if (m_left == 1 && exp_q.size() > 0) m_result = exp_q.pop_front();
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 1 && exp_q.size() > 0) m_result = exp_q.pop_front();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_busy", {31'b0, bus.busy}, {31'b0, (m_left > 1)});
      check("cyc_done", {31'b0, bus.done}, {31'b0, (m_left == 1)});
      check("cyc_result", bus.result, m_result);
    end
  end

  task automatic issue_now(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue_now(f3, a, b);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    drive_start(f3, a, b);
    wait_done(lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, bus.result, exp_res);
  endtask

  initial begin
    int lat1, lat2;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.a      = '0;
    bus.b      = '0;
    bus.flush  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_7xm3",     F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh_7xm3",    F3_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu_max",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu_m1x2",  F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhsu_min",   F3_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT);
    run_op("mulh_minsq",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mul_zero",     F3_MUL,    32'd0,          32'h1234_5678, 32'd0,         MUL_LAT);
    run_op("div_m20_6",    F3_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 34);
    run_op("rem_m20_6",    F3_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 34);
    run_op("divu_20_6",    F3_DIVU,   32'd20,         32'd6,         32'd3,         34);
    run_op("rem_20_m6",    F3_REM,    32'd20,         32'hFFFF_FFFA, 32'd2,         34);
    run_op("div_m7_2",     F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op("div_by0",      F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_by0",     F3_REMU,   32'd5,          32'd0,         32'd5,         1);
    run_op("div_ovf",      F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",      F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    run_op("divu_max_1",   F3_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34);

    // Flush at T10 of a DIVU; a new op at T12 then runs normally.
    drive_start(F3_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_done", {31'b0, bus.done}, 32'd0);
    check("flush_result", bus.result, 32'hFFFF_FFFF);
    run_op("after_flush", F3_DIVU, 32'd100, 32'd7, 32'd14, 34);

    // flush together with start in DONE: start is dropped.
    bus.flush = 1'b1;
    issue_now(F3_DIVU, 32'd9, 32'd2);
    bus.flush = 1'b0;
    check("flush_start_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_start_done", {31'b0, bus.done}, 32'd0);

    // Back-to-back: start held in the DONE cycle is accepted with no gap.
    drive_start(F3_DIVU, 32'd20, 32'd6);
    wait_done(lat1);
    issue_now(F3_REMU, 32'd20, 32'd6);
    check("b2b_nogap", {31'b0, bus.busy}, 32'd1);
    wait_done(lat2);
    lat2 = lat2 + 1;
    check("b2b_lat1", lat1, 32'd34);
    check("b2b_total", lat1 + lat2, 32'd69);
    check("b2b_res", bus.result, 32'd2);

    // Asynchronous reset mid-operation at T5.
    drive_start(F3_DIVU, 32'd50, 32'd5);
    repeat (4) @(negedge clk);
    check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst_mul", F3_MUL, 32'd3, 32'd5, 32'd15, MUL_LAT);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
